// File: rtl/uart_pkg.sv
// Shared defaults and receiver state encoding for the 8N1 UART receiver.
package uart_pkg;

    localparam int CLK_FREQ_DEF = 50_000_000;
    localparam int BAUD_DEF     = 9600;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus a third flop for falling-edge detection.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_async,
    output logic rx_sync,
    output logic rx_fall
);

    logic [2:0] sync_q;

    // Flops reset to 1 so an idle-high line never looks like an edge after reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[1:0], rx_async};
        end
    end

    assign rx_sync = sync_q[1];
    assign rx_fall = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/uart.sv
// Receive-only 8N1 UART; the last good byte is shown on led.
// Define UART_STOP_CHECK_EN to discard frames whose stop-bit sample is 0.
module uart
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = CLK_FREQ_DEF,
    parameter int BAUD     = BAUD_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_uart,
    output logic [7:0] led
);

    localparam int BIT_CYCLES = CLK_FREQ / BAUD;
    localparam int CW         = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] HALF_C = CW'(BIT_CYCLES / 2);
    localparam logic [CW-1:0] LOAD_C = CW'(BIT_CYCLES / 2 + 1);
    localparam logic [CW-1:0] LAST_C = CW'(BIT_CYCLES - 1);

    logic          rx_s;
    logic          rx_fall;
    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_q;
    logic          mid;
    logic          wrap;
    logic          shift_en;
    logic          load_led;
`ifdef UART_STOP_CHECK_EN
    logic          stop_bit;
`endif

    uart_rx_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_async (rx_uart),
        .rx_sync  (rx_s),
        .rx_fall  (rx_fall)
    );

    assign mid  = (cnt == HALF_C);
    assign wrap = (cnt == LAST_C);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (rx_fall) state_next = START;
            START: begin
                if (mid && rx_s) state_next = IDLE;
                else if (wrap)   state_next = DATA;
            end
            DATA:  if (wrap && bit_idx == 3'd7) state_next = STOP;
            // Leave one clock after the stop sample so led loads, then go idle
            // well before the next start edge can arrive.
            STOP:  if (cnt == LOAD_C) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        shift_en = (state == DATA) && mid;
        load_led = (state == STOP) && (cnt == LOAD_C);
`ifdef UART_STOP_CHECK_EN
        load_led = load_led && stop_bit;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
            shift_q <= 8'h00;
            led     <= 8'h00;
        end else begin
            if (state == IDLE || wrap) cnt <= '0;
            else                       cnt <= cnt + CW'(1);

            if (state != DATA) bit_idx <= 3'd0;
            else if (wrap)     bit_idx <= bit_idx + 3'd1;

            if (shift_en) shift_q[bit_idx] <= rx_s;
            if (load_led) led <= shift_q;
        end
    end

`ifdef UART_STOP_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst_n)                        stop_bit <= 1'b1;
        else if (state == STOP && mid)    stop_bit <= rx_s;
    end
`endif

endmodule

// File: tb/tb_uart.sv
// Directed bench for the uart receiver, scaled to 20 clocks per bit.
module tb_uart;
    import uart_pkg::*;

    localparam int BIT = 20;

    logic       clk;
    logic       rst_n;
    logic       rx_uart;
    logic [7:0] led;

    int checks;
    int errors;

    uart #(.CLK_FREQ(1_000_000), .BAUD(50_000)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx_uart (rx_uart),
        .led     (led)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic send_bit(input logic b);
        rx_uart = b;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
        send_bit(stop);
        rx_uart = 1'b1;
    endtask

    task automatic idle(input int n);
        rx_uart = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        rx_uart = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (led !== 8'h00) begin
            errors++; $display("FAIL reset_led: got %h expected 00", led);
        end
        checks++;
        if (dut.state !== IDLE) begin
            errors++; $display("FAIL reset_state: got %0d expected %0d", dut.state, IDLE);
        end
        rst_n = 1'b0;
        idle(100);
    endtask

    task automatic test_frame_31;
        logic [7:0] d;
        d = 8'h31;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        rx_uart = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (led !== 8'h00) begin
            errors++; $display("FAIL early_stop_led: got %h expected 00", led);
        end
        repeat (BIT - 5) @(negedge clk);
        checks++;
        if (led !== 8'h31) begin
            errors++; $display("FAIL frame_31: got %h expected 31", led);
        end
    endtask

    task automatic test_hold;
        logic [7:0] d;
        d = 8'hC3;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        checks++;
        if (led !== 8'h31) begin
            errors++; $display("FAIL hold_led: got %h expected 31", led);
        end
        checks++;
        if (dut.state !== DATA) begin
            errors++; $display("FAIL hold_state: got %0d expected %0d", dut.state, DATA);
        end
        for (int i = 4; i < 8; i++) send_bit(d[i]);
        send_bit(1'b1);
        checks++;
        if (led !== 8'hC3) begin
            errors++; $display("FAIL frame_c3: got %h expected c3", led);
        end
    endtask

    task automatic test_frame_ff;
        send_frame(8'hFF, 1'b1);
        checks++;
        if (led !== 8'hFF) begin
            errors++; $display("FAIL frame_ff: got %h expected ff", led);
        end
        idle(3 * BIT);
        checks++;
        if (led !== 8'hFF) begin
            errors++; $display("FAIL idle_ff: got %h expected ff", led);
        end
    endtask

    task automatic test_glitch;
        rx_uart = 1'b0;
        repeat (2) @(negedge clk);
        idle(BIT + 10);
        checks++;
        if (led !== 8'hFF) begin
            errors++; $display("FAIL glitch_led: got %h expected ff", led);
        end
        checks++;
        if (dut.state !== IDLE) begin
            errors++; $display("FAIL glitch_state: got %0d expected %0d", dut.state, IDLE);
        end
        send_frame(8'hA5, 1'b1);
        checks++;
        if (led !== 8'hA5) begin
            errors++; $display("FAIL frame_a5: got %h expected a5", led);
        end
    endtask

    task automatic test_back_to_back;
        send_frame(8'h96, 1'b1);
        checks++;
        if (led !== 8'h96) begin
            errors++; $display("FAIL b2b_first: got %h expected 96", led);
        end
        send_frame(8'h0F, 1'b1);
        checks++;
        if (led !== 8'h0F) begin
            errors++; $display("FAIL b2b_second: got %h expected 0f", led);
        end
        idle(2 * BIT);
    endtask

    task automatic test_bad_stop;
        logic [7:0] exp_led;
`ifdef UART_STOP_CHECK_EN
        exp_led = 8'h0F;
`else
        exp_led = 8'h5A;
`endif
        send_frame(8'h5A, 1'b0);
        idle(2 * BIT);
        checks++;
        if (led !== exp_led) begin
            errors++; $display("FAIL bad_stop: got %h expected %h", led, exp_led);
        end
    endtask

    task automatic test_mid_reset;
        logic [7:0] d;
        d = 8'hE7;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        rx_uart = d[4];
        repeat (BIT / 2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        checks++;
        if (led !== 8'h00) begin
            errors++; $display("FAIL mid_reset_led: got %h expected 00", led);
        end
        checks++;
        if (dut.state !== IDLE) begin
            errors++; $display("FAIL mid_reset_state: got %0d expected %0d", dut.state, IDLE);
        end
        idle(12 * BIT);
        send_frame(8'h3C, 1'b1);
        checks++;
        if (led !== 8'h3C) begin
            errors++; $display("FAIL frame_3c: got %h expected 3c", led);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b1;
        rx_uart = 1'b1;
        @(negedge clk);
        test_reset;
        test_frame_31;
        test_hold;
        test_frame_ff;
        test_glitch;
        test_back_to_back;
        test_bad_stop;
        test_mid_reset;
        idle(BIT);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart.md
UART -- requirements
Module: uart

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, serial bit rate in bit/s.
REQ-003 SHALL have port clk, input, 1 bit, the single system clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, synchronous active-high reset, sampled on the clk rising edge.
REQ-005 SHALL have port rx_uart, input, 1 bit, asynchronous serial receive line, idle high.
REQ-006 SHALL have port led, output, 8 bits, last correctly received data byte, registered.

Function
REQ-007 SHALL be a receive-only 8N1 UART: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
REQ-008 SHALL define BIT_CYCLES = CLK_FREQ/BAUD with integer truncation; the default is 5208 clocks per bit.
REQ-009 SHALL pass rx_uart through a 2-flop synchronizer, plus a third flop for edge detection, before any use.
REQ-010 SHALL use states IDLE, START, DATA and STOP, and SHALL leave IDLE on a synchronized falling edge of rx_uart.
REQ-011 SHALL run a bit-period counter 0..BIT_CYCLES-1 that wraps to 0 and advances the bit index on wrap; the counter SHALL be held at 0 in IDLE.
REQ-012 SHALL sample each bit once, when the counter equals BIT_CYCLES/2 (mid-bit).
REQ-013 SHALL, in START, return to IDLE without a byte if the mid-bit sample is 1 (glitch rejection).
REQ-014 SHALL, in DATA, shift the mid-bit sample into bit position [index] for index 0..7.
REQ-015 SHALL, in STOP, load the assembled byte into led on the clock after the stop-bit mid-point sample, then return to IDLE.
REQ-016 SHALL ignore falling edges that occur while not in IDLE.
REQ-017 SHALL leave led unchanged between frames and while a frame is in progress.
REQ-018 SHALL accept back-to-back frames: a start edge arriving half a bit after the stop-bit sample SHALL be detected.

Reset
REQ-019 SHALL, while rst_n=1, force state=IDLE, all counters to 0, the synchronizer flops to 1 and led to 8'h00.
REQ-020 SHALL abandon any frame in progress on reset, with no led update.
REQ-021 SHALL resume normal operation on the first clock after rst_n returns to 0.

Configuration
REQ-022 SHALL support macro UART_STOP_CHECK_EN; when defined, a stop-bit sample of 0 SHALL discard the byte, leaving led unchanged.
REQ-023 SHALL, without UART_STOP_CHECK_EN, load led after the stop-bit sample regardless of its value.

Structure
REQ-024 SHALL place the defaults for CLK_FREQ and BAUD and the state enumeration in shared package uart_pkg.
REQ-025 SHALL implement the synchronizer and falling-edge detector as sub-module uart_rx_sync; everything else SHALL be in uart.

Verification
REQ-026 Reset: hold rst_n=1 for 10 cycles with rx_uart=1 -> led=8'h00, state IDLE.
REQ-027 Frame 0x31: release reset, then after 100 cycles send start 0, bits 1,0,0,0,1,1,0,0 and stop 1, each 104000 ns -> led=8'h31 about 0.5 bit after stop start.
REQ-028 Frame 0xFF: send start 0, then line held high -> led=8'hFF; a following idle period leaves led at 8'hFF.
REQ-029 Glitch: a low pulse of 1000 ns in IDLE -> no led change; the receiver returns to IDLE and the next valid frame 8'hA5 is received.
REQ-030 Bad stop: send 8'h5A with stop=0 -> led unchanged with UART_STOP_CHECK_EN, led=8'h5A without it.
REQ-031 Mid-frame reset: assert rst_n during bit 4 of a frame -> led=8'h00, and the next full frame 8'h3C is received correctly.
